// File: rtl/activ_skew_feeder_if.sv
// Handshake and output bundle of the activation skew feeder.
// master: activation buffer side; slave: the feeder itself.
interface activ_skew_feeder_if #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*DATA_W-1:0] in_data;
  logic                   in_last;
  logic [ROWS*DATA_W-1:0] out_activ;
  logic [ROWS-1:0]        out_valid;
  logic                   done;
  logic [CNT_W-1:0]       vec_count;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_activ, out_valid,
    input  done, vec_count
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_activ, out_valid,
    output done, vec_count
  );
endinterface

// File: rtl/activ_skew_feeder.sv
// Diagonal skew of activation vectors into the array west edge.
// Ports: clk, rst (sync, active high), bus (slave modport).
// Macro BUBBLE_ZERO_EN: bubbles carry zero data, else hold.
module activ_skew_feeder #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst,
  activ_skew_feeder_if.slave bus
);

  localparam int DCW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t           state;
  logic [DCW-1:0]   drain_cnt;
  logic             done_q;
  logic [CNT_W-1:0] vec_cnt_q;
  logic             rdy;
  logic             acc;

  logic [ROWS*DATA_W-1:0] activ_w;
  logic [ROWS-1:0]        valid_w;

  assign rdy = (state != DRAIN);
  assign acc = bus.in_valid && rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      done_q    <= 1'b0;
      vec_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (acc) begin
        if (state == IDLE)
          vec_cnt_q <= CNT_W'(1);
        else if (!(&vec_cnt_q))
          vec_cnt_q <= vec_cnt_q + CNT_W'(1);
      end
      unique case (state)
        IDLE, STREAM: begin
          if (acc) begin
            if (!bus.in_last) begin
              state <= STREAM;
            end else if (ROWS == 1) begin
              // single row: last element already out next cycle
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DCW'(ROWS - 1);
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - DCW'(1);
          if (drain_cnt == DCW'(1)) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_W-1:0] d_q [0:r];
    logic [r:0]        v_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= r; i++)
          d_q[i] <= '0;
        v_q <= '0;
      end else begin
        v_q[0] <= acc;
        if (acc)
          d_q[0] <= bus.in_data[r*DATA_W +: DATA_W];
`ifdef BUBBLE_ZERO_EN
        else
          d_q[0] <= '0;
`endif
        for (int i = 1; i <= r; i++) begin
          d_q[i] <= d_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end

    assign activ_w[r*DATA_W +: DATA_W] = d_q[r];
    assign valid_w[r] = v_q[r];
  end

  assign bus.in_ready  = rdy;
  assign bus.out_activ = activ_w;
  assign bus.out_valid = valid_w;
  assign bus.done      = done_q;
  assign bus.vec_count = vec_cnt_q;

endmodule

// File: tb/tb_activ_skew_feeder.sv
// Random and directed bench for activ_skew_feeder.
// Reference: per-edge history of the row-0 slot, read back skewed.
module tb_activ_skew_feeder;

  localparam int R  = 4;
  localparam int W  = 8;
  localparam int VW = R * W;
  localparam int HN = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  activ_skew_feeder_if #(.ROWS(R), .DATA_W(W), .CNT_W(16)) b4 ();
  activ_skew_feeder_if #(.ROWS(1), .DATA_W(W), .CNT_W(16)) b1 ();

  activ_skew_feeder #(.ROWS(R), .DATA_W(W), .CNT_W(16)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  activ_skew_feeder #(.ROWS(1), .DATA_W(W), .CNT_W(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  int checks   = 0;
  int failures = 0;

  // model state
  bit          started = 0;
  int          e = -1;
  int          blk = 0;
  bit          open_f = 0;
  logic [15:0] vc = '0;
  bit          hv [0:HN-1];
  logic [VW-1:0] hd [0:HN-1];
  bit          done_at [0:HN+R];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < HN; i++) begin
      hv[i] = 0;
      hd[i] = '0;
    end
    for (int i = 0; i <= HN + R; i++)
      done_at[i] = 0;
  end

  always @(posedge clk) begin
    bit rdy;
    bit acc;
    e = e + 1;
    started = 1;
    rdy = (e == 0) ? 1'b1 : ((e - 1) >= blk);
    acc = b4.in_valid && rdy && !rst;
    if (rst) begin
      vc = '0;
      open_f = 0;
      blk = 0;
      for (int j = 0; j <= R; j++)
        done_at[e+j] = 0;
      for (int j = 0; j < R; j++) begin
        if (e - j >= 0) begin
          hv[e-j] = 0;
          hd[e-j] = '0;
        end
      end
    end else begin
      hv[e] = acc;
      if (acc)
        hd[e] = b4.in_data;
`ifdef BUBBLE_ZERO_EN
      else
        hd[e] = '0;
`else
      else
        hd[e] = (e > 0) ? hd[e-1] : '0;
`endif
      if (acc) begin
        if (!open_f)
          vc = 16'd1;
        else if (vc != 16'hFFFF)
          vc = vc + 16'd1;
        if (b4.in_last) begin
          open_f = 0;
          blk = e + R - 1;
          done_at[e+R-1] = 1;
        end else begin
          open_f = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int r = 0; r < R; r++) begin
        int idx;
        logic ev;
        logic [W-1:0] ed;
        idx = e - r;
        ev = (idx >= 0) ? hv[idx] : 1'b0;
        ed = (idx >= 0) ? hd[idx][r*W +: W] : '0;
        chk($sformatf("row%0d_valid", r),
            64'(b4.out_valid[r]), 64'(ev));
        chk($sformatf("row%0d_data", r),
            64'(b4.out_activ[r*W +: W]), 64'(ed));
      end
      chk("done", 64'(b4.done), 64'(done_at[e]));
      chk("in_ready", 64'(b4.in_ready),
          64'(e >= blk));
      chk("vec_count", 64'(b4.vec_count), 64'(vc));
    end
  end

  task automatic tick(input logic v,
                      input logic l,
                      input logic [VW-1:0] d);
    b4.in_valid = v;
    b4.in_last  = l;
    b4.in_data  = d;
    @(negedge clk);
    #1;
  endtask

  task automatic frame1();
    tick(1'b1, 1'b1, 32'h04030201);
    chk("t1_c1_valid", 64'(b4.out_valid), 64'h1);
    chk("t1_c1_row0", 64'(b4.out_activ[7:0]), 64'h01);
    chk("t1_c1_ready", 64'(b4.in_ready), 64'h0);
    chk("t1_c1_vc", 64'(b4.vec_count), 64'h1);
    tick(1'b0, 1'b0, '0);
    chk("t1_c2_valid", 64'(b4.out_valid), 64'h2);
    chk("t1_c2_row1", 64'(b4.out_activ[15:8]), 64'h02);
    chk("t1_c2_ready", 64'(b4.in_ready), 64'h0);
    tick(1'b0, 1'b0, '0);
    chk("t1_c3_valid", 64'(b4.out_valid), 64'h4);
    chk("t1_c3_row2", 64'(b4.out_activ[23:16]), 64'h03);
    chk("t1_c3_ready", 64'(b4.in_ready), 64'h0);
    chk("t1_c3_done", 64'(b4.done), 64'h0);
    tick(1'b0, 1'b0, '0);
    chk("t1_c4_valid", 64'(b4.out_valid), 64'h8);
    chk("t1_c4_row3", 64'(b4.out_activ[31:24]), 64'h04);
    chk("t1_c4_done", 64'(b4.done), 64'h1);
    chk("t1_c4_ready", 64'(b4.in_ready), 64'h1);
  endtask

  initial begin
    b4.in_valid = 1'b0;
    b4.in_last  = 1'b0;
    b4.in_data  = '0;
    b1.in_valid = 1'b0;
    b1.in_last  = 1'b0;
    b1.in_data  = '0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    tick(1'b0, 1'b0, '0);
    rst = 1'b0;
    chk("rst_valid", 64'(b4.out_valid), 64'h0);
    chk("rst_activ", 64'(b4.out_activ), 64'h0);
    chk("rst_ready", 64'(b4.in_ready), 64'h1);
    chk("rst_vc", 64'(b4.vec_count), 64'h0);

    frame1();

    // next frame starts in the done cycle
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'(i == 7), VW'($urandom));
      if (i == 0)
        chk("s8_vc_first", 64'(b4.vec_count), 64'h1);
    end
    chk("s8_vc", 64'(b4.vec_count), 64'd8);
    chk("s8_ready", 64'(b4.in_ready), 64'h0);
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("s8_nodone", 64'(b4.done), 64'h0);
    tick(1'b0, 1'b0, '0);
    chk("s8_done", 64'(b4.done), 64'h1);

    // two-cycle gap mid-frame
    for (int i = 0; i < 3; i++)
      tick(1'b1, 1'b0, VW'($urandom));
    tick(1'b0, 1'b1, VW'($urandom));
    chk("gap_row0", 64'(b4.out_valid[0]), 64'h0);
    tick(1'b0, 1'b0, VW'($urandom));
    tick(1'b1, 1'b0, VW'($urandom));
    tick(1'b1, 1'b1, VW'($urandom));
    for (int i = 0; i < R; i++)
      tick(1'b0, 1'b0, '0);

    // reset while draining
    tick(1'b1, 1'b1, 32'h11223344);
    tick(1'b0, 1'b0, '0);
    rst = 1'b1;
    tick(1'b0, 1'b0, '0);
    rst = 1'b0;
    chk("rd_valid", 64'(b4.out_valid), 64'h0);
    chk("rd_activ", 64'(b4.out_activ), 64'h0);
    chk("rd_done", 64'(b4.done), 64'h0);
    chk("rd_ready", 64'(b4.in_ready), 64'h1);
    chk("rd_vc", 64'(b4.vec_count), 64'h0);
    for (int i = 0; i < 3; i++)
      tick(1'b0, 1'b0, '0);
    frame1();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      tick(1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 9) < 2),
           VW'($urandom));
    end
    rst = 1'b0;
    for (int i = 0; i < R + 1; i++)
      tick(1'b0, 1'b0, '0);

    // single-row instance
    chk("r1_ready0", 64'(b1.in_ready), 64'h1);
    b1.in_valid = 1'b1;
    b1.in_last  = 1'b1;
    b1.in_data  = 8'hAB;
    tick(1'b0, 1'b0, '0);
    b1.in_valid = 1'b0;
    b1.in_last  = 1'b0;
    chk("r1_valid", 64'(b1.out_valid), 64'h1);
    chk("r1_data", 64'(b1.out_activ), 64'hAB);
    chk("r1_done", 64'(b1.done), 64'h1);
    chk("r1_ready", 64'(b1.in_ready), 64'h1);
    chk("r1_vc", 64'(b1.vec_count), 64'h1);
    for (int i = 0; i < 4; i++) begin
      b1.in_valid = 1'b1;
      b1.in_last  = 1'(i == 3);
      b1.in_data  = W'(8'h10 + i);
      tick(1'b0, 1'b0, '0);
      chk("r1s_ready", 64'(b1.in_ready), 64'h1);
      chk("r1s_data", 64'(b1.out_activ), 64'(8'h10 + i));
      chk("r1s_done", 64'(b1.done), 64'(i == 3));
    end
    b1.in_valid = 1'b0;
    b1.in_last  = 1'b0;
    chk("r1s_vc", 64'(b1.vec_count), 64'd4);
    tick(1'b0, 1'b0, '0);
    chk("r1_idle_valid", 64'(b1.out_valid), 64'h0);
    chk("r1_idle_done", 64'(b1.done), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
